// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: shared state encodings and requester IDs for the multiplier sequencer
package mul_sequencer_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic REQ_INT = 1'b0;
  localparam logic REQ_FPU = 1'b1;
endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: two-requester multiply bus with result/status lines
interface mul_sequencer_if #(parameter int WIDTH = 32);
  logic                 req0_valid;
  logic [WIDTH-1:0]     req0_a;
  logic [WIDTH-1:0]     req0_b;
  logic                 req0_signed;
  logic                 req0_ready;
  logic                 req1_valid;
  logic [WIDTH-1:0]     req1_a;
  logic [WIDTH-1:0]     req1_b;
  logic                 req1_signed;
  logic                 req1_ready;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic                 done_id;
  logic [2*WIDTH-1:0]   product;
  modport master (
    output req0_valid, req0_a, req0_b, req0_signed,
    output req1_valid, req1_a, req1_b, req1_signed, flush,
    input  req0_ready, req1_ready, busy, done, done_id, product
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_signed,
    input  req1_valid, req1_a, req1_b, req1_signed, flush,
    output req0_ready, req1_ready, busy, done, done_id, product
  );
endinterface

// File: rtl/mul_sequencer_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with last-grant memory
module rr_arbiter2
  import mul_sequencer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_accept,
  output logic o_grant
);
  logic r_last;
  assign o_grant = (i_valid0 & i_valid1) ? ~r_last : i_valid1;
  // remember the winner so a tie next time goes to the other requester
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_last <= REQ_FPU;
    else if (i_accept) r_last <= o_grant;
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: shared iterative shift-add multiplier with round-robin request sequencing
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  mul_sequencer_if.slave  bus
);
  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_acc;
  logic [CNTW-1:0]    r_cnt;
  logic               r_neg;
  logic               r_id;
  logic [2*WIDTH-1:0] r_product;
  logic               w_grant;
  logic               w_idle;
  logic               w_accept;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_s;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_full;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_valid0 (bus.req0_valid),
    .i_valid1 (bus.req1_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign w_idle         = r_state == S_IDLE;
  assign bus.req0_ready = reset & w_idle & ~bus.flush & bus.req0_valid & (w_grant == REQ_INT);
  assign bus.req1_ready = reset & w_idle & ~bus.flush & bus.req1_valid & (w_grant == REQ_FPU);
  assign w_accept       = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);
  assign w_a            = w_grant ? bus.req1_a : bus.req0_a;
  assign w_b            = w_grant ? bus.req1_b : bus.req0_b;
  assign w_s            = w_grant ? bus.req1_signed : bus.req0_signed;
  assign w_sum          = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
  assign w_full         = {r_acc, r_mplr};
  assign bus.busy       = ~w_idle;
  assign bus.done       = r_state == S_DONE;
  assign bus.done_id    = r_id;
  assign bus.product    = r_product;

  // sequencer FSM and shift-add datapath; magnitudes are multiplied, sign applied in FIX
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_id      <= REQ_INT;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand <= (w_s & w_a[WIDTH-1]) ? -w_a : w_a;
      r_mplr  <= (w_s & w_b[WIDTH-1]) ? -w_b : w_b;
      r_neg   <= w_s & (w_a[WIDTH-1] ^ w_b[WIDTH-1]);
      r_id    <= w_grant;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_state <= S_RUN;
    end else if (r_state == S_RUN) begin
      if (bus.flush) r_state <= S_IDLE;
      else begin
        r_acc  <= w_sum[WIDTH:1];
        r_mplr <= {w_sum[0], r_mplr[WIDTH-1:1]};
        r_cnt  <= r_cnt + 1'b1;
        if (r_cnt == CNTW'(WIDTH - 1)) r_state <= S_FIX;
      end
    end else if (r_state == S_FIX) begin
      r_state <= bus.flush ? S_IDLE : S_DONE;
      if (!bus.flush) r_product <= r_neg ? -w_full : w_full;
    end else if (r_state == S_DONE) r_state <= S_IDLE;
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench for the shared multiplier sequencer
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;
  localparam int W = 32;
  typedef struct packed {logic id; logic [63:0] p;} exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mul_sequencer_if #(.WIDTH(W)) bus ();
  mul_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t        sb[$];
  logic        gq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          t_acc = 0;
  int          arb_acc = 0;
  int          idle_cnt = 0;
  logic        arb_phase = 1'b0;
  logic [63:0] last_p = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sbv;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    return s ? 64'(sa * sbv) : {32'b0, a} * {32'b0, b};
  endfunction

  // monitor: push expectations on accept, compare on done
  always @(negedge clk) if (reset) begin
    cyc++;
    if (arb_phase && !bus.busy && arb_acc >= 1 && arb_acc < 4) idle_cnt++;
    if (bus.req0_valid && bus.req0_ready) begin
      sb.push_back('{1'b0, model(bus.req0_a, bus.req0_b, bus.req0_signed)});
      gq.push_back(1'b0);
      t_acc = cyc;
      if (arb_phase) arb_acc++;
    end
    if (bus.req1_valid && bus.req1_ready) begin
      sb.push_back('{1'b1, model(bus.req1_a, bus.req1_b, bus.req1_signed)});
      gq.push_back(1'b1);
      t_acc = cyc;
      if (arb_phase) arb_acc++;
    end
    if (bus.done) begin
      if (sb.size() == 0) chk("spurious_done", 64'(bus.done), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", bus.product, e.p);
        chk("done_id", 64'(bus.done_id), 64'(e.id));
        chk("latency", 64'(cyc - t_acc), 64'd34);
        last_p = e.p;
      end
    end
  end

  task automatic idle_all;
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_signed = 0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_signed = 0;
    bus.flush = 0;
  endtask

  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic s, output int waited);
    logic got;
    got = 0;
    waited = 0;
    if (id) begin bus.req1_a = a; bus.req1_b = b; bus.req1_signed = s; bus.req1_valid = 1; end
    else begin bus.req0_a = a; bus.req0_b = b; bus.req0_signed = s; bus.req0_valid = 1; end
    while (!got && waited < 50) begin
      @(negedge clk);
      waited++;
      got = id ? bus.req1_ready : bus.req0_ready;
    end
    @(posedge clk);
    #1;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    chk("accept_timeout", 64'(got), 64'd1);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int w;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_done_id", 64'(bus.done_id), 64'd0);
    chk("rst_product", bus.product, 64'd0);
    chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("rst_ready1", 64'(bus.req1_ready), 64'd0);
    idle_all();
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1;

    issue(0, 32'd7, 32'd6, 0, w); drain();
    chk("p_7x6", bus.product, 64'd42);
    issue(0, 32'hFFFF_FFFD, 32'd5, 1, w); drain();
    chk("p_neg3x5", bus.product, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, w); drain();
    chk("p_max_u", bus.product, 64'hFFFF_FFFE_0000_0001);
    issue(0, 32'h8000_0000, 32'h8000_0000, 1, w); drain();
    chk("p_min_s", bus.product, 64'h4000_0000_0000_0000);
    issue(1, 32'd0, 32'h1234_5678, 0, w); drain();
    chk("p_zero", bus.product, 64'd0);
    for (int i = 0; i < 4; i++) begin
      issue(1, $urandom, $urandom, 1'($urandom_range(1)), w);
      drain();
    end

    gq.delete();
    arb_phase = 1;
    bus.req0_a = 32'd11; bus.req0_b = 32'd13; bus.req0_signed = 0;
    bus.req1_a = 32'hFFFF_FFF9; bus.req1_b = 32'd9; bus.req1_signed = 1;
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    for (int n = 0; n < 400 && arb_acc < 4; n++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    arb_phase = 0;
    drain();
    chk("arb_count", 64'(gq.size()), 64'd4);
    for (int i = 0; i < 4; i++) if (i < gq.size()) chk("arb_grant", 64'(gq[i]), 64'(i % 2));
    chk("arb_idle_gaps", 64'(idle_cnt), 64'd3);

    issue(0, 32'd3, 32'd4, 0, w);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1;
    @(posedge clk);
    #1 bus.flush = 0;
    if (sb.size() != 0) void'(sb.pop_back());
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_done", 64'(bus.done), 64'd0);
    chk("flush_product", bus.product, last_p);
    issue(1, 32'd100, 32'd200, 0, w);
    chk("flush_reaccept", 64'(w), 64'd1);
    drain();
    chk("p_100x200", bus.product, 64'd20000);

    issue(0, 32'd5, 32'd5, 0, w);
    bus.req0_a = 32'd9; bus.req0_b = 32'd9;
    bus.req1_a = 32'd2; bus.req1_b = 32'd3;
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    repeat (4) @(posedge clk);
    #3 reset = 0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_product", bus.product, 64'd0);
    chk("mid_rst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("mid_rst_ready1", 64'(bus.req1_ready), 64'd0);
    sb.delete();
    gq.delete();
    @(posedge clk);
    #1 reset = 1;
    for (int n = 0; n < 20 && gq.size() == 0; n++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    chk("rst_tie_count", 64'(gq.size()), 64'd1);
    if (gq.size() != 0) chk("rst_tie_grant", 64'(gq[0]), 64'd0);
    drain();
    chk("p_9x9", bus.product, 64'd81);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
